// File: rtl/data_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_array_ctrl
// Purpose  : Cache data-array sequencer: CPU word reads/writes and 4-beat line
//            refills onto a single-port 64x128 SRAM with byte write enables.
// Revision : 1.0 - initial release
// ============================================================================
module data_array_ctrl (
    input  logic         clk,
    input  logic         rstn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [5:0]   req_index,
    input  logic [1:0]   req_offset,
    input  logic [3:0]   req_wstrb,
    input  logic [31:0]  req_wdata,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    input  logic         fill_valid,
    output logic         fill_ready,
    input  logic [5:0]   fill_index,
    input  logic [31:0]  fill_data,
    input  logic         fill_last,
    output logic         fill_done,
    output logic         CS,
    output logic         OE,
    output logic [15:0]  WEB,
    output logic [5:0]   A,
    output logic [127:0] DI,
    input  logic [127:0] DO
);

    localparam int WORDS = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RSP  = 3'd3,
        FILL = 3'd4,
        FWR  = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        req_hs;
    logic        fill_hs;

    logic [5:0]  req_idx_q;
    logic [1:0]  req_off_q;
    logic        req_wr_q;
    logic [3:0]  req_strb_q;
    logic [31:0] req_wdata_q;

    logic [5:0]  fill_idx_q;
    logic [2:0]  count;
    logic [31:0] buf_word [WORDS];
    logic [127:0] buf_line;

    assign req_hs   = req_valid & req_ready;
    assign fill_hs  = fill_valid & fill_ready;
    assign buf_line = {buf_word[3], buf_word[2], buf_word[1], buf_word[0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_idx_q   <= 6'd0;
            req_off_q   <= 2'd0;
            req_wr_q    <= 1'b0;
            req_strb_q  <= 4'd0;
            req_wdata_q <= 32'd0;
        end else if (state == IDLE && req_hs) begin
            req_idx_q   <= req_index;
            req_off_q   <= req_offset;
            req_wr_q    <= req_write;
            req_strb_q  <= req_wstrb;
            req_wdata_q <= req_wdata;
        end
    end

    // Beat 0 always lands in word 0, so a new refill never sees stale count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_idx_q <= 6'd0;
            count      <= 3'd0;
            for (int i = 0; i < WORDS; i++) begin
                buf_word[i] <= 32'd0;
            end
        end else if (fill_hs) begin
            if (state == IDLE) begin
                buf_word[0] <= fill_data;
                fill_idx_q  <= fill_index;
                count       <= 3'd1;
            end else begin
                buf_word[count[1:0]] <= fill_data;
                count                <= count + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fill_hs) begin
                    state_nxt = fill_last ? FWR : FILL;
                end else if (req_hs) begin
                    state_nxt = req_write ? WR : RD;
                end
            end
            RD:   state_nxt = RSP;
            WR:   state_nxt = RSP;
            RSP:  state_nxt = IDLE;
            FILL: begin
                if (fill_hs && (fill_last || count == 3'd3)) begin
                    state_nxt = FWR;
                end
            end
            FWR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        fill_ready = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = 32'd0;
        fill_done  = 1'b0;
        CS         = 1'b0;
        OE         = 1'b0;
        WEB        = 16'hFFFF;
        A          = 6'd0;
        DI         = 128'd0;
        case (state)
            IDLE: begin
                fill_ready = 1'b1;
                req_ready  = ~fill_valid;
            end
            RD: begin
                CS = 1'b1;
                OE = 1'b1;
                A  = req_idx_q;
            end
            WR: begin
                CS = 1'b1;
                A  = req_idx_q;
                DI = {WORDS{req_wdata_q}};
                WEB[{req_off_q, 2'b00} +: 4] = ~req_strb_q;
            end
            RSP: begin
                rsp_valid = 1'b1;
                OE        = 1'b1;
                if (!req_wr_q) begin
                    rsp_rdata = DO[{req_off_q, 5'b00000} +: 32];
                end
            end
            FILL: begin
                fill_ready = 1'b1;
            end
            FWR: begin
                CS        = 1'b1;
                A         = fill_idx_q;
                DI        = buf_line;
                fill_done = 1'b1;
                // Only the received words are enabled; the rest keep SRAM contents.
                for (int i = 0; i < WORDS; i++) begin
                    if (count > 3'(i)) begin
                        WEB[i*4 +: 4] = 4'h0;
                    end
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/data_array_ctrl.md
DATA_ARRAY_CTRL -- requirements
Module: data_array_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rstn listed first.
REQ-002 Port list (name, direction, width, meaning) SHALL be:
- clk, in, 1: rising-edge clock, shared with the SRAM CK.
- rstn, in, 1: asynchronous active-low reset.
- req_valid, in, 1: CPU word request valid.
- req_ready, out, 1: CPU request accepted this cycle.
- req_write, in, 1: 1 = write, 0 = read.
- req_index, in, 6: line index.
- req_offset, in, 2: word within the line.
- req_wstrb, in, 4: byte enables, active-high.
- req_wdata, in, 32: write data.
- rsp_valid, out, 1: one-cycle response pulse.
- rsp_rdata, out, 32: read data; 0 for writes.
- fill_valid, in, 1: refill beat valid.
- fill_ready, out, 1: refill beat accepted.
- fill_index, in, 6: refill line index, sampled on beat 0.
- fill_data, in, 32: refill word.
- fill_last, in, 1: final refill beat.
- fill_done, out, 1: one-cycle pulse when the line write is issued.
- CS, out, 1: SRAM chip select.
- OE, out, 1: SRAM output enable.
- WEB, out, 16: SRAM byte write enables, active-low.
- A, out, 6: SRAM address.
- DI, out, 128: SRAM write data.
- DO, in, 128: SRAM read data, valid the cycle after the read edge.

Function
REQ-003 The block SHALL implement states IDLE, RD, WR, RSP, FILL and FWR.
REQ-004 IDLE outputs:
- fill_ready=1.
- req_ready = !fill_valid, so a refill wins over a CPU request in the same cycle.
REQ-005 A request handshake in IDLE SHALL latch index, offset, write, wstrb and wdata, then go to WR if req_write=1, otherwise RD.
REQ-006 RD (one cycle): CS=1, OE=1, WEB=16'hFFFF, A=latched index; next state RSP.
REQ-007 WR (one cycle):
- CS=1, OE=0, A=latched index.
- DI = wdata replicated 4 times.
- WEB[offset*4+k] = !wstrb[k] for k=0..3; all other WEB bits 1.
- Next state RSP.
REQ-008 RSP (one cycle):
- rsp_valid=1, CS=0, OE=1.
- rsp_rdata = DO[offset*32 +: 32] for a read; 0 for a write.
- Next state IDLE.
REQ-009 Request latency SHALL be fixed: handshake at cycle T, SRAM edge at T+1, rsp_valid at T+2; throughput is at most one request per 3 cycles.
REQ-010 A fill beat accepted in IDLE SHALL:
- store fill_data in buffer word 0 and latch fill_index;
- set the beat count to 1;
- go to FWR if fill_last=1, otherwise FILL.
REQ-011 In FILL:
- fill_ready=1 and req_ready=0.
- Each beat stores buffer word [count] and increments count.
- Go to FWR when fill_last=1 or the accepted beat is word 3.
- Cycles with fill_valid=0 hold state.
REQ-012 FWR (one cycle):
- CS=1, A=latched fill index, DI = 128-bit buffer, fill_done=1.
- WEB bits 0 for every received word (4*count bits from bit 0); remaining bits 1.
- Next state IDLE.
REQ-013 An early fill_last (fewer than 4 beats) SHALL write only the received words; unreceived words keep their SRAM contents.
REQ-014 Whenever CS=0, the SRAM outputs SHALL be A=0, DI=0, WEB=16'hFFFF.
REQ-015 fill_ready and req_ready SHALL both be 0 in RD, WR, RSP and FWR.
REQ-016 Request fields are don't-care without a handshake; the block SHALL NOT issue an SRAM access without a prior handshake.

Reset
REQ-017 While rstn=0, regardless of clk:
- state=IDLE, count=0, buffer=0;
- CS=0, OE=0, WEB=16'hFFFF, A=0, DI=0;
- rsp_valid=0, rsp_rdata=0, fill_done=0.
REQ-018 Reset asserted mid-RD, mid-WR or mid-FILL SHALL abort the operation: no response, no line write, and partial fill data discarded.
REQ-019 After rstn deasserts, the block SHALL accept a handshake on the first rising edge.

Verification
REQ-020 Full refill, then reads:
- Stimulus: 4 beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 to index 5.
- Response: one FWR with WEB=16'h0000, A=5, fill_done pulse.
- Stimulus: read index 5, offset 2.
- Response: rsp_rdata=0x33333333 exactly 2 cycles after the handshake.
REQ-021 Partial write:
- Stimulus: write index 5, offset 1, wstrb=4'b0011, wdata=0xAABBCCDD.
- Response: WEB=16'hFFCF.
- Stimulus: read offset 1.
- Response: 0x2222CCDD.
REQ-022 Simultaneous events:
- Stimulus: req_valid and fill_valid asserted in the same IDLE cycle.
- Response: fill accepted, req_ready=0 until the FWR completes, then the request is served.
REQ-023 Early fill_last:
- Stimulus: 2 beats to index 9, fill_last on beat 1.
- Response: WEB=16'hFF00; words 2-3 unchanged.
REQ-024 Reset during fill:
- Stimulus: rstn low after 2 of 4 beats.
- Response: no CS pulse, outputs at reset values, next fill starts at buffer word 0.
REQ-025 Back-to-back reads:
- Stimulus: req_valid held high.
- Response: handshakes every 3 cycles; rsp_valid is never high for 2 consecutive cycles.
